// File: rtl/matrix_op_sequencer_pkg.sv
// Shared types and constants for the matrix add/subtract sequencer.
package matrix_op_sequencer_pkg;

  localparam int DEFAULT_MATRIX_SIZE = 8;
  localparam int DEFAULT_ELEM_WIDTH  = 16;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_A,
    LOAD_B,
    STREAM,
    DONE
  } state_t;

  // Element index width; kept at least 1 bit so a 1x1 matrix still elaborates.
  function automatic int idx_width(input int n);
    return (n * n > 1) ? $clog2(n * n) : 1;
  endfunction

endpackage

// File: rtl/matrix_op_sequencer_elem_addsub.sv
// Combinational element arithmetic: y = a + b (add) or b - a (subtract), wrapping.
module elem_addsub
  import matrix_op_sequencer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_ELEM_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mode,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    if (mode == MODE_SUB) y = b - a;
    else                  y = a + b;
  end

endmodule

// File: rtl/matrix_op_sequencer.sv
// Loads two NxN operands row-major, then streams their element-wise sum or difference.
//
// state  | meaning
// IDLE   | waiting for start; mode latched on acceptance
// LOAD_A | accepting N*N elements of operand A
// LOAD_B | accepting N*N elements of operand B
// STREAM | emitting N*N results with valid/ready handshake
// DONE   | one-cycle done pulse, then back to IDLE
module matrix_op_sequencer
  import matrix_op_sequencer_pkg::*;
#(
  parameter int MATRIX_SIZE = DEFAULT_MATRIX_SIZE,
  parameter int ELEM_WIDTH  = DEFAULT_ELEM_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  mode,
  output logic                  busy,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ELEM_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ELEM_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  done
);

  localparam int NUM_ELEMS = MATRIX_SIZE * MATRIX_SIZE;
  localparam int IDX_W     = idx_width(MATRIX_SIZE);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ELEMS - 1);

  state_t state, state_nxt;
  logic [IDX_W-1:0] idx;
  logic             mode_q;
  logic             in_hs, out_hs, at_last;
  logic [ELEM_WIDTH-1:0] result;

  // Operand storage is deliberately unreset; it is only read in STREAM, after a full reload.
  logic [ELEM_WIDTH-1:0] mat_a [NUM_ELEMS];
  logic [ELEM_WIDTH-1:0] mat_b [NUM_ELEMS];

  assign in_hs   = in_valid & in_ready;
  assign out_hs  = out_valid & out_ready;
  assign at_last = (idx == LAST_IDX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start)            state_nxt = LOAD_A;
      LOAD_A:  if (in_hs && at_last) state_nxt = LOAD_B;
      LOAD_B:  if (in_hs && at_last) state_nxt = STREAM;
      STREAM:  if (out_hs && at_last) state_nxt = DONE;
      DONE:                          state_nxt = IDLE;
      default:                       state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != IDLE);
    in_ready  = (state == LOAD_A) || (state == LOAD_B);
    out_valid = (state == STREAM);
    out_last  = (state == STREAM) && at_last;
    done      = (state == DONE);
  end

  // Index and latched mode; the index wraps to 0 at the end of every phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx    <= '0;
      mode_q <= MODE_ADD;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            idx    <= '0;
            mode_q <= mode;
          end
        end
        LOAD_A, LOAD_B: begin
          if (in_hs) idx <= at_last ? '0 : idx + 1'b1;
        end
        STREAM: begin
          if (out_hs) idx <= at_last ? '0 : idx + 1'b1;
        end
        default: idx <= '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == LOAD_A && in_hs) mat_a[idx] <= in_data;
    if (state == LOAD_B && in_hs) mat_b[idx] <= in_data;
  end

  elem_addsub #(
    .WIDTH (ELEM_WIDTH)
  ) u_elem_addsub (
    .a    (mat_a[idx]),
    .b    (mat_b[idx]),
    .mode (mode_q),
    .y    (result)
  );

  assign out_data = out_valid ? result : '0;

endmodule

// File: tb/tb_matrix_op_sequencer.sv
// Directed self-checking bench for matrix_op_sequencer with N=8, 16-bit elements.
module tb_matrix_op_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        mode = 1'b0;
  logic        busy;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_data;
  logic        out_last;
  logic        done;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] a_vec   [64];
  logic [15:0] b_vec   [64];
  logic [15:0] exp_vec [64];

  always #5 clk = ~clk;

  matrix_op_sequencer #(
    .MATRIX_SIZE (8),
    .ELEM_WIDTH  (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .mode      (mode),
    .busy      (busy),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .done      (done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One full operation. pre: start is already high in IDLE; hold: leave start high afterwards.
  task automatic run_op(input bit m, input bit gaps, input bit stall, input bit disturb,
                        input bit hold, input bit pre, input bit timed);
    int k, cyc, guard, stall_cnt;
    bit tog;
    mode = m;
    if (!pre) begin
      @(posedge clk); #1;
      start = 1'b1;
    end
    cyc = 1;
    @(posedge clk); #1;
    start = hold;
    cyc++;
    k = 0; guard = 0; tog = 1'b1;
    while (k < 128 && guard < 1000) begin
      in_valid = gaps ? tog : 1'b1;
      tog = ~tog;
      in_data = !in_valid ? 16'hDEAD : (k < 64 ? a_vec[k] : b_vec[k-64]);
      if (disturb) begin
        start = (k >= 5 && k < 8);
        mode  = ~m;
      end
      #1;
      if (k == 0 || k == 64) check("load_ready", 32'(in_ready), 32'd1);
      if (in_valid && in_ready) k++;
      @(posedge clk); #1;
      cyc++; guard++;
    end
    if (guard >= 1000) check("load_timeout", 32'd0, 32'd1);
    start = hold;
    in_valid = 1'b1;
    in_data = 16'hBEEF;
    k = 0; guard = 0; stall_cnt = 0;
    while (k < 64 && guard < 1000) begin
      out_ready = !(stall && k == 10 && stall_cnt < 3);
      #1;
      check("out_valid", 32'(out_valid), 32'd1);
      check("out_data", 32'(out_data), 32'(exp_vec[k]));
      check("out_last", 32'(out_last), 32'(k == 63));
      if (k == 0) check("stream_in_ready", 32'(in_ready), 32'd0);
      if (!out_ready) stall_cnt++;
      else k++;
      @(posedge clk); #1;
      cyc++; guard++;
    end
    if (guard >= 1000) check("stream_timeout", 32'd0, 32'd1);
    if (stall) check("stall_cycles", 32'(stall_cnt), 32'd3);
    in_valid = 1'b0;
    out_ready = 1'b1;
    #1;
    check("done_pulse", 32'(done), 32'd1);
    check("done_busy", 32'(busy), 32'd1);
    check("done_out_valid", 32'(out_valid), 32'd0);
    if (timed) check("latency", 32'(cyc), 32'd194);
    @(posedge clk); #2;
    check("done_once", 32'(done), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_in_ready", 32'(in_ready), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #3;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Add: A=k, B=2k -> 3k, fastest path
    for (int i = 0; i < 64; i++) begin
      a_vec[i] = 16'(i); b_vec[i] = 16'(2 * i); exp_vec[i] = 16'(3 * i);
    end
    run_op(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Subtract wrap: 3 - 5 = 0xFFFE
    for (int i = 0; i < 64; i++) begin
      a_vec[i] = 16'h0005; b_vec[i] = 16'h0003; exp_vec[i] = 16'hFFFE;
    end
    run_op(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Input gaps and 3-cycle backpressure at k=10, same results as the first run
    for (int i = 0; i < 64; i++) begin
      a_vec[i] = 16'(i); b_vec[i] = 16'(2 * i); exp_vec[i] = 16'(3 * i);
    end
    run_op(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset after 20 A elements of junk
    @(posedge clk); #1;
    start = 1'b1; mode = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1; in_data = 16'h7777;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd0);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("postrst_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 64; i++) begin
      a_vec[i] = 16'(257 * i); b_vec[i] = 16'(16'h1000 + i); exp_vec[i] = 16'(258 * i + 16'h1000);
    end
    run_op(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Start with flipped mode mid-operation: ignored, subtract result kept
    for (int i = 0; i < 64; i++) begin
      a_vec[i] = 16'(i); b_vec[i] = 16'h0100; exp_vec[i] = 16'(16'h0100 - i);
    end
    run_op(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);

    // Back-to-back with start held through done
    for (int i = 0; i < 64; i++) begin
      a_vec[i] = 16'hFFFF; b_vec[i] = 16'(i + 1); exp_vec[i] = 16'(i);
    end
    run_op(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 64; i++) begin
      a_vec[i] = 16'(i); b_vec[i] = 16'(3 * i); exp_vec[i] = 16'(2 * i);
    end
    run_op(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    start = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/matrix_op_sequencer.md
MATRIX_OP_SEQUENCER -- requirements
Module: matrix_op_sequencer

Interface
REQ-001 SHALL have parameter MATRIX_SIZE, default 8: matrix dimension N (NxN matrices).
REQ-002 SHALL have parameter ELEM_WIDTH, default 16: element width in bits.
REQ-003 SHALL have port clk, input, 1: sole clock; all state changes on the rising edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-005 SHALL have port start, input, 1: request to begin one matrix operation.
REQ-006 SHALL have port mode, input, 1: 0 = add (A+B), 1 = subtract (B-A); sampled only when start is accepted.
REQ-007 SHALL have port busy, output, 1: high in every state except IDLE.
REQ-008 SHALL have port in_valid, input, 1: in_data carries a valid element.
REQ-009 SHALL have port in_ready, output, 1: block accepts an element this cycle.
REQ-010 SHALL have port in_data, input, ELEM_WIDTH: operand element stream.
REQ-011 SHALL have port out_valid, output, 1: out_data carries a valid result element.
REQ-012 SHALL have port out_ready, input, 1: downstream accepts the result element.
REQ-013 SHALL have port out_data, output, ELEM_WIDTH: result element stream.
REQ-014 SHALL have port out_last, output, 1: high with out_valid on the final result element.
REQ-015 SHALL have port done, output, 1: one-cycle pulse after the final result handshake.

Function
REQ-016 SHALL implement the FSM states IDLE, LOAD_A, LOAD_B, STREAM and DONE.
REQ-017 IDLE: start=1 SHALL latch mode, clear the element index and move to LOAD_A on the next edge.
REQ-018 LOAD_A / LOAD_B: in_ready=1; each in_valid&in_ready cycle SHALL store in_data at the current index and increment the index.
REQ-019 Element order SHALL be row-major, index 0 = [0][0] and index N*N-1 = [N-1][N-1], for both inputs and the output.
REQ-020 On the N*N-th accepted element, LOAD_A SHALL go to LOAD_B and LOAD_B SHALL go to STREAM, with the index reset to 0 in both cases.
REQ-021 STREAM: out_valid=1; out_data SHALL be A[k]+B[k] (mode 0) or B[k]-A[k] (mode 1), truncated modulo 2^ELEM_WIDTH with no saturation or carry output.
REQ-022 STREAM: the index k SHALL advance only on out_valid&out_ready; out_data and out_last SHALL remain stable while out_ready=0.
REQ-023 out_last SHALL be high only in STREAM when k = N*N-1.
REQ-024 The handshake on k = N*N-1 SHALL move the FSM to DONE; DONE SHALL assert done for exactly one cycle and then return to IDLE.
REQ-025 The fastest operation SHALL take 3*N*N+2 cycles from start accepted to done (N=8: 194).
REQ-026 start SHALL be ignored while busy=1; a mode change mid-operation SHALL have no effect.
REQ-027 in_ready SHALL be 0 outside LOAD_A and LOAD_B, and in_valid SHALL be ignored there.
REQ-028 in_valid=0 gaps SHALL stall loading with no loss or duplication of elements.
REQ-029 out_valid SHALL be 0 outside STREAM.
REQ-030 A start that coincides with the done cycle SHALL be ignored; a new start SHALL be accepted from IDLE on the following cycle.

Reset
REQ-031 rst=1 SHALL immediately force IDLE, set the index to 0 and drive busy, in_ready, out_valid, out_last and done to 0.
REQ-032 Assertion of rst mid-operation SHALL abort the operation; partially loaded operands SHALL be discarded, and the next operation SHALL reload both operands in full.
REQ-033 Operand storage is not required to reset; its contents SHALL never be observable before they are fully reloaded.

Structure
REQ-034 A shared package SHALL hold the FSM state enumeration, MODE_ADD=0, MODE_SUB=1 and the default MATRIX_SIZE and ELEM_WIDTH constants.
REQ-035 The element arithmetic SHALL be a separate combinational sub-module, elem_addsub (inputs a, b, mode; output y).
REQ-036 The sequencer SHALL instantiate exactly one elem_addsub, shared across all N*N elements.
REQ-037 Operand storage SHALL be two N*N x ELEM_WIDTH register arrays indexed by a log2(N*N)-bit counter.

Verification
REQ-038 Add: mode=0, A[k]=k, B[k]=2k, out_ready=1 throughout -> out_data=3k for k=0..63; out_last at k=63; done 194 cycles after start.
REQ-039 Subtract wrap: mode=1, A[k]=0x0005, B[k]=0x0003 -> every out_data=0xFFFE.
REQ-040 Backpressure and gaps: in_valid toggled 1/0 and out_ready held low for 3 cycles at k=10 -> out_data at k=10 held stable; the result sequence is identical to the unstalled run.
REQ-041 Reset mid-load: rst pulsed after 20 A elements, then a fresh full operation -> results depend only on the new operands; busy=0 during and immediately after reset.
REQ-042 start during an operation with the mode flipped -> ignored; the result matches the original mode; done pulses once.
REQ-043 Back-to-back: start held high through done -> second operation begins on the cycle after IDLE is re-entered; both result sets are correct.
